gcd_controller: RTL
===================

# gcd_controller

Control FSM for the 16-bit subtractive GCD datapath (`GCD_datapath`). It accepts two operands from an upstream valid/ready stream and steers them onto the datapath bus. It then iterates compare-and-subtract steps using the datapath's `gt`/`lt`/`eq` flags until the operands are equal, and reports completion, step count and timeout. The result is read from the datapath's A register after `done`.

## Interface
Parameters:
- `ITER_W`, 16: width of the step counter.
- `MAX_ITER`, 2**ITER_W-1: step limit; reaching it without `eq` raises `err`.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a new GCD; sampled only in IDLE.
- `op_valid`  in  1  upstream operand valid; operand bits drive datapath `data_in` directly.
- `op_ready`  out  1  controller accepts the operand this cycle.
- `gt`, `lt`, `eq`  in  1 each  datapath compare flags (A vs B).
- `ldA`, `ldB`  out  1 each  datapath register load enables.
- `sel1`, `sel2`  out  1 each  subtractor operand muxes: 1 selects A, 0 selects B.
- `sel_in`  out  1  bus mux: 1 selects `data_in`, 0 selects subtractor output.
- `busy`  out  1  high from operand load through compare loop.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle pulse with `done` on step-limit timeout.
- `iter_cnt`  out  ITER_W  subtraction steps in current/last job.

## Operation
- States: IDLE, LOAD_A, LOAD_B, COMP, DONE.
- Default outputs in every state: `ldA`, `ldB`, `sel1`, `sel2`, `sel_in`, `op_ready`, `done`, `err` all 0.
- IDLE:
  - `start`=1 → LOAD_A.
  - Clears `iter_cnt` to 0 on the transition.
- LOAD_A:
  - `op_ready`=1 and `sel_in`=1.
  - `ldA`=`op_valid`.
  - On `op_valid` → LOAD_B; otherwise hold.
- LOAD_B: same as LOAD_A using `ldB`; on `op_valid` → COMP.
- COMP (Mealy on flags):
  - `eq` → DONE, no load.
  - Else if `iter_cnt`==MAX_ITER → DONE with timeout flag set, no load.
  - Else if `gt`: `sel1`=1, `sel2`=0, `sel_in`=0, `ldA`=1 (A ← A−B), `iter_cnt`+1.
  - Else if `lt`: `sel1`=0, `sel2`=1, `sel_in`=0, `ldB`=1 (B ← B−A), `iter_cnt`+1.
- DONE:
  - `done`=1, `err`=timeout flag.
  - Unconditionally → IDLE; timeout flag cleared there.
- `busy`=1 in LOAD_A, LOAD_B and COMP; 0 in IDLE and DONE.
- `start` outside IDLE is ignored; no queuing.
- Arithmetic:
  - `iter_cnt` is unsigned, never wraps; the limit check precedes the increment.
  - `iter_cnt` holds its value after DONE until the next accepted `start`.
- Zero operands:
  - (0,0) → `eq` immediately, result 0, no `err`.
  - (0,n) or (n,0) with n≠0 never converge and must terminate via timeout.

## Timing
- Reset (asynchronous): state IDLE, `iter_cnt`=0, timeout flag 0, every output 0.
- Reset mid-job aborts immediately; datapath register contents are don't-care afterwards.
- Operand handshake: transfer occurs in the cycle where `op_valid` && `op_ready`. Datapath register updates on that edge.
- Compare flags are valid in the cycle after the B load, so COMP needs no settle state.
- Latency with `op_valid` held high and `start` at cycle 0:
  - LOAD_A at 1, LOAD_B at 2, first COMP at 3.
  - `done` at cycle 4+N, where N = subtraction steps.
  - Each `op_valid` stall cycle adds 1.
- Timeout latency: `done`/`err` at cycle 4+MAX_ITER.
- Back-to-back: `start` is accepted in the IDLE cycle directly after DONE, i.e. one cycle after `done`.

## Test plan
- (12,8), `start` at cycle 0, `op_valid` always 1 → A: 12→4, then B: 8→4. `done`=1 at cycle 6, `err`=0, `iter_cnt`=2, A=4.
- (7,7) → `done` at cycle 4, `iter_cnt`=0, A=7. Also (0,0) → `done` at cycle 4, A=0, `err`=0.
- (65535,1) with default params → `iter_cnt`=65534, A=1, `err`=0. Also (0,5) with MAX_ITER=8 → `done`=`err`=1 at cycle 12, `iter_cnt`=8.
- (48,18) with `op_valid` low for 3 cycles before each operand → `op_ready` held, no spurious `ldA`/`ldB`. A=6, `iter_cnt`=4, `done` 6 cycles later than the no-stall case.
- `start` pulsed during COMP → ignored, job unaffected. A second `start` one cycle after `done` is accepted, and `iter_cnt` clears.
- `rst` asserted mid-COMP of (100,3) → same cycle: all outputs 0 and `busy`=0. After release, a new (9,6) job gives A=3, `iter_cnt`=2.

Source files
------------

// File: rtl/gcd_controller.sv
// rtl/gcd_controller.sv - control FSM for the 16-bit subtractive GCD datapath
module gcd_controller #(
    parameter int          ITER_W   = 16,
    parameter int unsigned MAX_ITER = (2 ** ITER_W) - 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic              gt,
    input  logic              lt,
    input  logic              eq,
    output logic              ldA,
    output logic              ldB,
    output logic              sel1,
    output logic              sel2,
    output logic              sel_in,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ITER_W-1:0] iter_cnt
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        COMP   = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [ITER_W-1:0] MAX_CNT = ITER_W'(MAX_ITER);

    state_t state;
    state_t state_nxt;
    logic   timeout_q;
    logic   cnt_clr;
    logic   cnt_inc;
    logic   timeout_set;

    // State register; reset aborts any job in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Step counter and sticky timeout flag; the counter is held after DONE so it can be read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iter_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (cnt_clr) begin
                iter_cnt <= '0;
            end else if (cnt_inc) begin
                iter_cnt <= iter_cnt + ITER_W'(1);
            end
            if (timeout_set) begin
                timeout_q <= 1'b1;
            end else if (state == IDLE) begin
                timeout_q <= 1'b0;
            end
        end
    end

    // Next-state and datapath steering; COMP decodes the compare flags combinationally.
    always_comb begin
        state_nxt   = state;
        ldA         = 1'b0;
        ldB         = 1'b0;
        sel1        = 1'b0;
        sel2        = 1'b0;
        sel_in      = 1'b0;
        op_ready    = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        busy        = 1'b0;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        timeout_set = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LOAD_A;
                    cnt_clr   = 1'b1;
                end
            end
            LOAD_A: begin
                busy     = 1'b1;
                op_ready = 1'b1;
                sel_in   = 1'b1;
                ldA      = op_valid;
                if (op_valid) begin
                    state_nxt = LOAD_B;
                end
            end
            LOAD_B: begin
                busy     = 1'b1;
                op_ready = 1'b1;
                sel_in   = 1'b1;
                ldB      = op_valid;
                if (op_valid) begin
                    state_nxt = COMP;
                end
            end
            COMP: begin
                busy = 1'b1;
                if (eq) begin
                    state_nxt = DONE;
                end else if (iter_cnt == MAX_CNT) begin
                    // Zero operands never converge; the limit check wins over another step.
                    state_nxt   = DONE;
                    timeout_set = 1'b1;
                end else if (gt) begin
                    sel1    = 1'b1;
                    ldA     = 1'b1;
                    cnt_inc = 1'b1;
                end else if (lt) begin
                    sel2    = 1'b1;
                    ldB     = 1'b1;
                    cnt_inc = 1'b1;
                end
            end
            DONE: begin
                done      = 1'b1;
                err       = timeout_q;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
